// File: rtl/proc_ctrl_fsm.sv
// Control unit for the simple processor: fetches a word into IR, decodes it and
// sequences the register enables, bus mux select and adder mode one state per cycle.
module proc_ctrl_fsm #(
   parameter int IR_W  = 16,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [IR_W-1:0]  IR_out,
   output logic             IR_in,
   output logic             pc_inc,
   output logic [7:0]       RX_in,
   output logic             A_in,
   output logic             G_in,
   output logic [SEL_W-1:0] sel,
   output logic             add_sub_ctrl,
   output logic             done,
   output logic             busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MV, S_IMM_FETCH,
      S_IMM_WR, S_ADD_A, S_ADD_G, S_ADD_W, S_NOP
   } state_t;

   localparam logic [2:0]       OP_MV  = 3'b000;
   localparam logic [2:0]       OP_MVI = 3'b001;
   localparam logic [2:0]       OP_ADD = 3'b010;
   localparam logic [2:0]       OP_SUB = 3'b011;
   localparam logic [SEL_W-1:0] SEL_IR = SEL_W'(8);
   localparam logic [SEL_W-1:0] SEL_G  = SEL_W'(9);

   state_t     state;
   logic [2:0] op, x, y;

   logic [2:0] ir_op, ir_x, ir_y;
   logic       unused_ir_lsbs;

   assign ir_op          = IR_out[IR_W-1 -: 3];
   assign ir_x           = IR_out[IR_W-4 -: 3];
   assign ir_y           = IR_out[IR_W-7 -: 3];
   assign unused_ir_lsbs = ^IR_out[IR_W-10:0];

   function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

   // Outputs are registered together with the state, so each branch loads the
   // outputs that belong to the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         op           <= '0;
         x            <= '0;
         y            <= '0;
         IR_in        <= 1'b0;
         pc_inc       <= 1'b0;
         RX_in        <= '0;
         A_in         <= 1'b0;
         G_in         <= 1'b0;
         sel          <= '0;
         add_sub_ctrl <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults first; a later assignment in the same
         // cycle wins, so every state only lists the outputs it raises.
         IR_in        <= 1'b0;
         pc_inc       <= 1'b0;
         RX_in        <= '0;
         A_in         <= 1'b0;
         G_in         <= 1'b0;
         sel          <= '0;
         add_sub_ctrl <= 1'b0;
         done         <= 1'b0;
         busy         <= 1'b1;

         case (state)
            S_IDLE: begin
               if (run) begin
                  state  <= S_FETCH;
                  IR_in  <= 1'b1;
                  pc_inc <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end

            S_FETCH: state <= S_DECODE;

            // IR is stable here; fields are latched because mvi overwrites IR.
            S_DECODE: begin
               op <= ir_op;
               x  <= ir_x;
               y  <= ir_y;
               case (ir_op)
                  OP_MV: begin
                     state <= S_MV;
                     sel   <= SEL_W'(ir_y);
                     RX_in <= reg_onehot(ir_x);
                     done  <= 1'b1;
                  end
                  OP_MVI: begin
                     state  <= S_IMM_FETCH;
                     IR_in  <= 1'b1;
                     pc_inc <= 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     state <= S_ADD_A;
                     sel   <= SEL_W'(ir_x);
                     A_in  <= 1'b1;
                  end
                  default: begin
                     state <= S_NOP;
                     done  <= 1'b1;
                  end
               endcase
            end

            S_IMM_FETCH: begin
               state <= S_IMM_WR;
               sel   <= SEL_IR;
               RX_in <= reg_onehot(x);
               done  <= 1'b1;
            end

            S_ADD_A: begin
               state        <= S_ADD_G;
               sel          <= SEL_W'(y);
               G_in         <= 1'b1;
               add_sub_ctrl <= (op == OP_SUB);
            end

            // Adder mode is held through the write-back cycle.
            S_ADD_G: begin
               state        <= S_ADD_W;
               sel          <= SEL_G;
               RX_in        <= reg_onehot(x);
               add_sub_ctrl <= add_sub_ctrl;
               done         <= 1'b1;
            end

            S_MV, S_IMM_WR, S_ADD_W, S_NOP: begin
               if (run) begin
                  state  <= S_FETCH;
                  IR_in  <= 1'b1;
                  pc_inc <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: a behavioural datapath and program memory around the
// controller, a per-cycle expected-output queue, and an invariant monitor.
module tb_proc_ctrl_fsm;

   typedef struct packed {
      logic       ir_in;
      logic       pc_inc;
      logic [7:0] rx_in;
      logic       a_in;
      logic       g_in;
      logic [3:0] sel;
      logic       add_sub;
      logic       done;
      logic       busy;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [15:0] ir_q;
   logic        IR_in, pc_inc, A_in, G_in, add_sub_ctrl, done, busy;
   logic [7:0]  RX_in;
   logic [3:0]  sel;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   obs_t        sb[$];
   logic [15:0] mem [256];
   logic [7:0]  pc;
   logic [15:0] rf [8];
   logic [15:0] rf_ref [8];
   logic [15:0] acc, g_q, bus, din;

   always #5 clk = ~clk;

   proc_ctrl_fsm #(.IR_W(16), .SEL_W(4)) dut (
      .clk(clk), .reset(reset), .run(run), .IR_out(ir_q),
      .IR_in(IR_in), .pc_inc(pc_inc), .RX_in(RX_in), .A_in(A_in), .G_in(G_in),
      .sel(sel), .add_sub_ctrl(add_sub_ctrl), .done(done), .busy(busy)
   );

   // Datapath model driven purely by the controller's enables.
   assign din = mem[pc];
   always_comb begin
      bus = 16'h0;
      if (sel < 4'd8)       bus = rf[sel[2:0]];
      else if (sel == 4'd8) bus = ir_q;
      else if (sel == 4'd9) bus = g_q;
   end

   always @(posedge clk) begin
      if (IR_in)  ir_q <= din;
      if (pc_inc) pc <= pc + 8'd1;
      if (A_in)   acc <= bus;
      if (G_in)   g_q <= add_sub_ctrl ? acc - bus : acc + bus;
      for (int i = 0; i < 8; i++)
         if (RX_in[i]) rf[i] <= bus;
   end

   // Structural invariants, checked every cycle once out of reset.
   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         assert ($onehot0(RX_in)
                 && (int'(IR_in) + int'(A_in) + int'(G_in) + int'(|RX_in)) <= 1
                 && pc_inc === IR_in && sel <= 4'd9)
         else begin
            n_err++;
            $error("FAIL invariant: IR_in=%b pc_inc=%b A_in=%b G_in=%b RX_in=%h sel=%0d",
                   IR_in, pc_inc, A_in, G_in, RX_in, sel);
         end
      end
   end

   function automatic obs_t rec(input logic ir, input logic pci, input logic [7:0] rx,
                                input logic a, input logic g, input logic [3:0] s,
                                input logic as_, input logic d, input logic b);
      return '{ir_in: ir, pc_inc: pci, rx_in: rx, a_in: a, g_in: g, sel: s,
               add_sub: as_, done: d, busy: b};
   endfunction

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x,
                                       input logic [2:0] y);
      return {op, x, y, 7'b0};
   endfunction

   // Expected cycle-by-cycle outputs from FETCH through the done cycle.
   task automatic push_instr(input logic [15:0] w);
      logic [2:0] op, x, y;
      op = w[15:13]; x = w[12:10]; y = w[9:7];
      sb.push_back(rec(1, 1, 8'h00, 0, 0, 4'd0, 0, 0, 1));
      sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 1));
      case (op)
         3'd0: sb.push_back(rec(0, 0, 8'd1 << x, 0, 0, {1'b0, y}, 0, 1, 1));
         3'd1: begin
            sb.push_back(rec(1, 1, 8'h00, 0, 0, 4'd0, 0, 0, 1));
            sb.push_back(rec(0, 0, 8'd1 << x, 0, 0, 4'd8, 0, 1, 1));
         end
         3'd2, 3'd3: begin
            sb.push_back(rec(0, 0, 8'h00, 1, 0, {1'b0, x}, 0, 0, 1));
            sb.push_back(rec(0, 0, 8'h00, 0, 1, {1'b0, y}, op[0], 0, 1));
            sb.push_back(rec(0, 0, 8'd1 << x, 0, 0, 4'd9, op[0], 1, 1));
         end
         default: sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 1, 1));
      endcase
   endtask

   task automatic step(input string tag);
      obs_t e, o;
      @(posedge clk);
      #1;
      n_vec++;
      o = '{ir_in: IR_in, pc_inc: pc_inc, rx_in: RX_in, a_in: A_in, g_in: G_in,
            sel: sel, add_sub: add_sub_ctrl, done: done, busy: busy};
      assert (sb.size() > 0) else begin
         n_err++;
         $error("FAIL %s: no expected entry, observed %h", tag, o);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
         end
      end
   endtask

   task automatic check_reg(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one instruction; stay=1 keeps run high so the next one follows directly.
   task automatic exec(input logic [15:0] w, input logic [15:0] imm, input bit stay,
                       input string tag);
      int n;
      logic [2:0] op, x, y;
      op = w[15:13]; x = w[12:10]; y = w[9:7];
      mem[pc] = w;
      mem[pc + 8'd1] = imm;
      n = sb.size();
      push_instr(w);
      n = sb.size() - n;
      case (op)
         3'd0: rf_ref[x] = rf_ref[y];
         3'd1: rf_ref[x] = imm;
         3'd2: rf_ref[x] = rf_ref[x] + rf_ref[y];
         3'd3: rf_ref[x] = rf_ref[x] - rf_ref[y];
         default: ;
      endcase
      run = 1'b1;
      for (int i = 0; i < n; i++) begin
         step(tag);
         if (i == 0) run = stay;
      end
      if (!stay) begin
         sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0));
         step({tag, "_idle"});
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      for (int i = 0; i < 8; i++) begin
         rf[i] = 16'h0;
         rf_ref[i] = 16'h0;
      end
      pc = 8'h0; ir_q = 16'h0; acc = 16'h0; g_q = 16'h0;
      reset = 1'b1;
      run   = 1'b0;
      repeat (2) @(posedge clk);
      sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0));
      reset = 1'b0;
      step("reset_state");
      chk_en = 1'b1;

      exec(16'h0080, 16'h0, 1'b0, "mv_r0_r1");
      exec(16'h2800, 16'h1234, 1'b0, "mvi_r2");
      check_reg("r2_after_mvi", rf[2], 16'h1234);

      exec(enc(3'd1, 3'd3, 3'd0), 16'd5, 1'b0, "mvi_r3");
      exec(enc(3'd1, 3'd4, 3'd0), 16'd7, 1'b0, "mvi_r4");
      exec(16'h4E00, 16'h0, 1'b0, "add_r3_r4");
      check_reg("r3_after_add", rf[3], 16'd12);
      exec(enc(3'd1, 3'd3, 3'd0), 16'd5, 1'b0, "mvi_r3b");
      exec(16'h6E00, 16'h0, 1'b0, "sub_r3_r4");
      check_reg("r3_after_sub", rf[3], 16'hFFFE);

      exec(enc(3'd2, 3'd4, 3'd4), 16'h0, 1'b0, "add_r4_r4");
      check_reg("r4_doubled", rf[4], 16'd14);

      exec(16'h0080, 16'h0, 1'b1, "b2b_mv");
      exec(16'h4E00, 16'h0, 1'b1, "b2b_add");
      exec(16'h8000, 16'h0, 1'b0, "b2b_nop");

      // Abort an mvi between IMM_FETCH and IMM_WR.
      mem[pc] = enc(3'd1, 3'd5, 3'd0);
      mem[pc + 8'd1] = 16'hBEEF;
      sb.push_back(rec(1, 1, 8'h00, 0, 0, 4'd0, 0, 0, 1));
      sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 1));
      sb.push_back(rec(1, 1, 8'h00, 0, 0, 4'd0, 0, 0, 1));
      run = 1'b1;
      step("abort_fetch");
      run = 1'b0;
      step("abort_decode");
      step("abort_imm_fetch");
      reset = 1'b1;
      sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0));
      step("abort_reset");
      reset = 1'b0;
      sb.push_back(rec(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0));
      step("abort_idle");
      check_reg("r5_untouched", rf[5], rf_ref[5]);
      exec(enc(3'd0, 3'd6, 3'd3), 16'h0, 1'b0, "restart_mv");

      for (int i = 0; i < 1000; i++) begin
         exec(enc(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))),
              16'($urandom), i != 999, "rand");
      end
      for (int i = 0; i < 8; i++) check_reg("rf_final", rf[i], rf_ref[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
